// File: rtl/tc_fetch_pkg.sv
// rtl/tc_fetch_pkg.sv - shared types and helpers for the instruction fetch stage
// Contents:
//   BYTE_W       width of one ROM byte
//   state_t      fetch FSM states (ISSUE, DRAIN, HOLD)
//   slot_offset  bit offset of byte slot k inside an assembled instruction word
package tc_fetch_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int unsigned slot_offset(input int unsigned k);
    return BYTE_W * k;
  endfunction

endpackage

// File: rtl/tc_byte_collector.sv
// rtl/tc_byte_collector.sv - slot-indexed byte write register holding one instruction word
// Ports:
//   clk      in   clock, rising edge
//   i_clear  in   synchronous clear of the whole word (wins over a write)
//   i_we     in   write i_data into byte slot i_slot
//   i_slot   in   byte slot index, byte k lands at bits [8k+7:8k]
//   i_data   in   byte to write
//   o_word   out  assembled word
module tc_byte_collector
  import tc_fetch_pkg::*;
#(
  parameter int unsigned INSN_BYTES = 4,
  parameter int unsigned SLOT_W     = 2
) (
  input  logic                         clk,
  input  logic                         i_clear,
  input  logic                         i_we,
  input  logic [SLOT_W-1:0]            i_slot,
  input  logic [BYTE_W-1:0]            i_data,
  output logic [BYTE_W*INSN_BYTES-1:0] o_word
);

  logic [BYTE_W*INSN_BYTES-1:0] r_word;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_word <= '0;
    end else if (i_we) begin
      for (int unsigned k = 0; k < INSN_BYTES; k++) begin
        if (i_slot == SLOT_W'(k)) begin
          r_word[slot_offset(k) +: BYTE_W] <= i_data;
        end
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/tc_insn_fetch8.sv
// rtl/tc_insn_fetch8.sv - byte-wide ROM instruction fetch with jump, halt and valid/ready output
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_addr     out  ROM byte address (combinational, pc + issue index)
//   mem_data     in   ROM data, valid the cycle after mem_addr
//   halt         in   suppress issuing new ROM reads (ISSUE state only)
//   jump_en      in   redirect fetch to jump_target, drops any partial or held instruction
//   jump_target  in   new pc
//   insn_valid   out  insn_out / insn_pc hold a complete instruction
//   insn_ready   in   downstream accept
//   insn_out     out  assembled instruction, byte k from address pc+k at bits [8k+7:8k]
//   insn_pc      out  address of byte 0 of insn_out
module tc_insn_fetch8
  import tc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       INSN_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [BYTE_W-1:0]            mem_data,
  input  logic                         halt,
  input  logic                         jump_en,
  input  logic [ADDR_W-1:0]            jump_target,
  output logic                         insn_valid,
  input  logic                         insn_ready,
  output logic [BYTE_W*INSN_BYTES-1:0] insn_out,
  output logic [ADDR_W-1:0]            insn_pc
);

  localparam int unsigned       INSN_W   = BYTE_W * INSN_BYTES;
  localparam int unsigned       SLOT_W   = (INSN_BYTES > 1) ? $clog2(INSN_BYTES) : 1;
  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(INSN_BYTES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [SLOT_W-1:0]   r_idx;
  logic                r_pending;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_insn_pc;
  logic                w_issue;
  logic                w_handshake;
  logic [INSN_W-1:0]   w_word;

  // Held at RESET_PC while rst is asserted so the ROM sees a defined address
  // even before the first reset edge has initialised the registers.
  assign mem_addr = rst ? RESET_PC : (r_pc + ADDR_W'(r_idx));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_handshake = r_valid && insn_ready;
    if (jump_en) begin
      w_state_nxt = ISSUE;
    end else begin
      case (r_state)
        ISSUE: begin
          if (!halt) begin
            w_issue = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = DRAIN;
            end
          end
        end
        DRAIN:   w_state_nxt = HOLD;
        HOLD:    if (w_handshake) w_state_nxt = ISSUE;
        default: w_state_nxt = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ISSUE;
      r_pc      <= RESET_PC;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_slot    <= '0;
      r_valid   <= 1'b0;
      r_insn_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (jump_en) begin
        // A jump also cancels a handshake in the same cycle: pc is not advanced.
        r_pc      <= jump_target;
        r_idx     <= '0;
        r_pending <= 1'b0;
        r_valid   <= 1'b0;
      end else begin
        case (r_state)
          ISSUE: begin
            r_pending <= w_issue;
            if (w_issue) begin
              r_slot <= r_idx;
              r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + SLOT_W'(1);
            end
          end
          DRAIN: begin
            // The last byte is captured at this same edge by the collector.
            r_pending <= 1'b0;
            r_valid   <= 1'b1;
            r_insn_pc <= r_pc;
          end
          HOLD: begin
            if (w_handshake) begin
              r_valid <= 1'b0;
              r_pc    <= r_pc + ADDR_W'(INSN_BYTES);
              r_idx   <= '0;
            end
          end
          default: begin
            r_pending <= 1'b0;
          end
        endcase
      end
    end
  end

  // A byte still arriving during a jump cycle is written but harmless: the
  // word is fully rewritten before insn_valid can rise again.
  tc_byte_collector #(
    .INSN_BYTES (INSN_BYTES),
    .SLOT_W     (SLOT_W)
  ) u_collector (
    .clk     (clk),
    .i_clear (rst),
    .i_we    (r_pending),
    .i_slot  (r_slot),
    .i_data  (mem_data),
    .o_word  (w_word)
  );

  assign insn_valid = r_valid;
  assign insn_out   = w_word;
  assign insn_pc    = r_insn_pc;

endmodule

// File: tb/tb_tc_insn_fetch8.sv
// tb/tb_tc_insn_fetch8.sv - directed self-checking bench for tc_insn_fetch8 with mem[a]=a ROM
module tb_tc_insn_fetch8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        halt = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_target = 8'h00;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn_out;
  logic [7:0]  insn_pc;

  int n_checks = 0;
  int n_fail   = 0;

  tc_insn_fetch8 #(
    .ADDR_W     (8),
    .INSN_BYTES (4),
    .RESET_PC   (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .halt        (halt),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready),
    .insn_out    (insn_out),
    .insn_pc     (insn_pc)
  );

  always #5 clk = ~clk;

  // Registered ROM with mem[a] = a.
  always @(posedge clk) mem_data <= mem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit into cycle 0, the first cycle after reset.
  task automatic reset_dut(input string tag);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    jump_en = 1'b0;
    halt    = 1'b0;
    tick(1);
    check({tag, "_rst_valid"}, {31'd0, insn_valid}, 32'd0);
    check({tag, "_rst_out"}, insn_out, 32'h0);
    check({tag, "_rst_pc"}, {24'd0, insn_pc}, 32'h0);
    check({tag, "_rst_addr"}, {24'd0, mem_addr}, 32'h0);
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    // T1: basic latency and throughput with ready held high
    insn_ready = 1'b1;
    reset_dut("t1");
    check("t1_c0_addr", {24'd0, mem_addr}, 32'h00);
    check("t1_c0_valid", {31'd0, insn_valid}, 32'd0);
    tick(4);
    check("t1_c4_valid", {31'd0, insn_valid}, 32'd0);
    tick(1);
    check("t1_c5_valid", {31'd0, insn_valid}, 32'd1);
    check("t1_c5_out", insn_out, 32'h03020100);
    check("t1_c5_pc", {24'd0, insn_pc}, 32'h00);
    tick(1);
    check("t1_c6_valid", {31'd0, insn_valid}, 32'd0);
    check("t1_c6_addr", {24'd0, mem_addr}, 32'h04);
    tick(4);
    check("t1_c10_valid", {31'd0, insn_valid}, 32'd0);
    tick(1);
    check("t1_c11_valid", {31'd0, insn_valid}, 32'd1);
    check("t1_c11_out", insn_out, 32'h07060504);
    check("t1_c11_pc", {24'd0, insn_pc}, 32'h04);

    // T2: backpressure keeps the instruction stable, one handshake follows
    insn_ready = 1'b0;
    reset_dut("t2");
    tick(5);
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_valid", {31'd0, insn_valid}, 32'd1);
      check("t2_hold_out", insn_out, 32'h03020100);
      check("t2_hold_pc", {24'd0, insn_pc}, 32'h00);
      tick(1);
    end
    insn_ready = 1'b1;
    tick(1);
    check("t2_c9_valid", {31'd0, insn_valid}, 32'd0);
    check("t2_c9_addr", {24'd0, mem_addr}, 32'h04);
    tick(5);
    check("t2_c14_valid", {31'd0, insn_valid}, 32'd1);
    check("t2_c14_out", insn_out, 32'h07060504);
    check("t2_c14_pc", {24'd0, insn_pc}, 32'h04);

    // T3: jump in cycle 2 of the first fetch
    insn_ready = 1'b1;
    reset_dut("t3");
    tick(2);
    jump_en     = 1'b1;
    jump_target = 8'h40;
    tick(1);
    jump_en = 1'b0;
    check("t3_c3_addr", {24'd0, mem_addr}, 32'h40);
    for (int c = 3; c < 8; c++) begin
      check("t3_no_valid", {31'd0, insn_valid}, 32'd0);
      tick(1);
    end
    check("t3_c8_valid", {31'd0, insn_valid}, 32'd1);
    check("t3_c8_out", insn_out, 32'h43424140);
    check("t3_c8_pc", {24'd0, insn_pc}, 32'h40);

    // T4: jump to 0xFE, addresses wrap through 0x00
    reset_dut("t4");
    jump_en     = 1'b1;
    jump_target = 8'hFE;
    tick(1);
    jump_en = 1'b0;
    check("t4_c1_addr", {24'd0, mem_addr}, 32'hFE);
    tick(5);
    check("t4_c6_valid", {31'd0, insn_valid}, 32'd1);
    check("t4_c6_out", insn_out, 32'h0100FFFE);
    check("t4_c6_pc", {24'd0, insn_pc}, 32'hFE);
    tick(6);
    check("t4_c12_valid", {31'd0, insn_valid}, 32'd1);
    check("t4_c12_out", insn_out, 32'h05040302);
    check("t4_c12_pc", {24'd0, insn_pc}, 32'h02);

    // T5: halt during cycles 1-2 delays valid to cycle 7
    reset_dut("t5");
    tick(1);
    halt = 1'b1;
    check("t5_c1_addr", {24'd0, mem_addr}, 32'h01);
    tick(2);
    halt = 1'b0;
    check("t5_c3_addr", {24'd0, mem_addr}, 32'h01);
    tick(3);
    check("t5_c6_valid", {31'd0, insn_valid}, 32'd0);
    tick(1);
    check("t5_c7_valid", {31'd0, insn_valid}, 32'd1);
    check("t5_c7_out", insn_out, 32'h03020100);
    check("t5_c7_pc", {24'd0, insn_pc}, 32'h00);

    // T6: reset pulse while holding an instruction
    insn_ready = 1'b0;
    reset_dut("t6");
    tick(5);
    check("t6_c5_valid", {31'd0, insn_valid}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_valid", {31'd0, insn_valid}, 32'd0);
    check("t6_rst_out", insn_out, 32'h0);
    insn_ready = 1'b1;
    tick(5);
    check("t6_refetch_valid", {31'd0, insn_valid}, 32'd1);
    check("t6_refetch_out", insn_out, 32'h03020100);
    check("t6_refetch_pc", {24'd0, insn_pc}, 32'h00);

    // T7: jump coincides with a handshake, no pc+4 advance
    insn_ready = 1'b0;
    reset_dut("t7");
    tick(6);
    check("t7_c6_valid", {31'd0, insn_valid}, 32'd1);
    insn_ready  = 1'b1;
    jump_en     = 1'b1;
    jump_target = 8'h80;
    tick(1);
    jump_en = 1'b0;
    check("t7_c7_valid", {31'd0, insn_valid}, 32'd0);
    check("t7_c7_addr", {24'd0, mem_addr}, 32'h80);
    tick(5);
    check("t7_c12_valid", {31'd0, insn_valid}, 32'd1);
    check("t7_c12_out", insn_out, 32'h83828180);
    check("t7_c12_pc", {24'd0, insn_pc}, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
